// File: rtl/wb_trace_buf_pkg.sv
// Shared constants for the retirement trace buffer: entry layout and counter width.
// An entry is packed as {pc, ena, reg[4:0], value} from MSB to LSB.
package wb_trace_buf_pkg;

  localparam int DROP_W = 16;
  localparam int REG_W  = 5;

  function automatic int entry_width(input int xlen);
    return 2 * xlen + 6;
  endfunction

  function automatic int value_lsb(input int xlen);
    return 0 * xlen;
  endfunction

  function automatic int reg_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int ena_bit(input int xlen);
    return xlen + REG_W;
  endfunction

  function automatic int pc_lsb(input int xlen);
    return xlen + REG_W + 1;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic synchronous FIFO with flush; pointers carry an extra wrap bit so that
// full/empty and level fall out of a plain subtraction.
module wb_trace_fifo #(
  parameter int WIDTH = 70,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_trace_buf.sv
// Retirement trace buffer: qualifies write-back events, packs them into entries,
// queues them for a ready/valid drain and counts captures lost to a full buffer.
module wb_trace_buf
  import wb_trace_buf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int FILTER = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   debug_wb_have_inst,
  input  logic [XLEN-1:0]        debug_wb_pc,
  input  logic                   debug_wb_ena,
  input  logic [4:0]             debug_wb_reg,
  input  logic [XLEN-1:0]        debug_wb_value,
  input  logic                   flush,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [XLEN-1:0]        trc_pc,
  output logic                   trc_ena,
  output logic [4:0]             trc_reg,
  output logic [XLEN-1:0]        trc_value,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int EW   = entry_width(XLEN);
  localparam int VLSB = value_lsb(XLEN);
  localparam int RLSB = reg_lsb(XLEN);
  localparam int EBIT = ena_bit(XLEN);
  localparam int PLSB = pc_lsb(XLEN);

  logic          capture;
  logic          reg_nz;
  logic          pop;
  logic          push;
  logic          full;
  logic          empty;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  assign reg_nz  = |debug_wb_reg;
  assign capture = debug_wb_have_inst & ((FILTER == 0) | (debug_wb_ena & reg_nz));
  assign push    = capture;
  assign pop     = trc_valid & trc_ready;

  // Fields that are not architecturally written are stored as zero, and x0 always reads 0.
  always_comb begin
    wdata                   = '0;
    wdata[PLSB +: XLEN]     = debug_wb_pc;
    wdata[EBIT]             = debug_wb_ena;
    if (debug_wb_ena) begin
      wdata[RLSB +: REG_W]  = debug_wb_reg;
      if (reg_nz) wdata[VLSB +: XLEN] = debug_wb_value;
    end
  end

  wb_trace_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(wdata),
    .rdata(rdata),
    .full (full),
    .empty(empty),
    .level(level)
  );

  assign trc_valid = ~empty;
  assign trc_pc    = trc_valid ? rdata[PLSB +: XLEN]  : '0;
  assign trc_ena   = trc_valid ? rdata[EBIT]          : 1'b0;
  assign trc_reg   = trc_valid ? rdata[RLSB +: REG_W] : '0;
  assign trc_value = trc_valid ? rdata[VLSB +: XLEN]  : '0;

  // A capture is lost only when full with no simultaneous pop; a flush swallows it silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= '0;
    end else if (capture && full && !pop && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_trace_buf.sv
// Directed self-checking bench for wb_trace_buf: a vector table for single-cycle
// behaviour plus hand-written sequences for fill, drop, wrap, flush and reset.
module tb_wb_trace_buf;

  logic        clk;
  logic        rst_n;
  logic        have_inst;
  logic [31:0] pc;
  logic        ena;
  logic [4:0]  rnum;
  logic [31:0] value;
  logic        flush;
  logic        ready;

  logic        trc_valid;
  logic [31:0] trc_pc;
  logic        trc_ena;
  logic [4:0]  trc_reg;
  logic [31:0] trc_value;
  logic [2:0]  level;
  logic [15:0] drop_cnt;

  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_ena;
  logic [4:0]  f_reg;
  logic [31:0] f_value;
  logic [2:0]  f_level;
  logic [15:0] f_drop;

  int tests_run = 0;
  int tests_failed = 0;

  wb_trace_buf #(.XLEN(32), .DEPTH(4), .FILTER(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .debug_wb_have_inst(have_inst), .debug_wb_pc(pc), .debug_wb_ena(ena),
    .debug_wb_reg(rnum), .debug_wb_value(value), .flush(flush),
    .trc_valid(trc_valid), .trc_ready(ready), .trc_pc(trc_pc), .trc_ena(trc_ena),
    .trc_reg(trc_reg), .trc_value(trc_value), .level(level), .drop_cnt(drop_cnt)
  );

  wb_trace_buf #(.XLEN(32), .DEPTH(4), .FILTER(1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .debug_wb_have_inst(have_inst), .debug_wb_pc(pc), .debug_wb_ena(ena),
    .debug_wb_reg(rnum), .debug_wb_value(value), .flush(flush),
    .trc_valid(f_valid), .trc_ready(ready), .trc_pc(f_pc), .trc_ena(f_ena),
    .trc_reg(f_reg), .trc_value(f_value), .level(f_level), .drop_cnt(f_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        have;
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rn;
    logic [31:0] val;
    logic        rdy;
    logic        valid_e;
    logic [31:0] pc_e;
    logic        ena_e;
    logic [4:0]  reg_e;
    logic [31:0] val_e;
    logic [2:0]  level_e;
  } vec_t;

  vec_t vecs [7];

  task automatic applyStimulus(input logic h, input logic [31:0] p, input logic e,
                               input logic [4:0] r, input logic [31:0] v,
                               input logic rdy, input logic fl);
    @(negedge clk);
    have_inst = h;
    pc        = p;
    ena       = e;
    rnum      = r;
    value     = v;
    ready     = rdy;
    flush     = fl;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    have_inst = 0; pc = 0; ena = 0; rnum = 0; value = 0; ready = 0; flush = 0;

    #1;
    checkOutput("reset valid", {63'd0, trc_valid}, 64'd0);
    checkOutput("reset level", {61'd0, level}, 64'd0);
    checkOutput("reset drop", {48'd0, drop_cnt}, 64'd0);
    checkOutput("reset pc", {32'd0, trc_pc}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //               have pc            ena rn    val            rdy valid pc_e          ena reg   val_e          lvl
    vecs[0] = '{1'b1, 32'h0000_0004, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 5'd5, 32'h1234_5678, 3'd1};
    vecs[1] = '{1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 3'd0};
    vecs[2] = '{1'b1, 32'h0000_0010, 1'b0, 5'd7, 32'h0000_DEAD, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 5'd0, 32'h0000_0000, 3'd1};
    vecs[3] = '{1'b1, 32'h0000_0014, 1'b1, 5'd0, 32'h0000_BEEF, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 5'd0, 32'h0000_0000, 3'd1};
    vecs[4] = '{1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0014, 1'b1, 5'd0, 32'h0000_0000, 3'd1};
    vecs[5] = '{1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 3'd0};
    vecs[6] = '{1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 3'd0};

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].have, vecs[i].pc, vecs[i].ena, vecs[i].rn, vecs[i].val, vecs[i].rdy, 1'b0);
      waitCycle();
      checkOutput($sformatf("vec%0d valid", i), {63'd0, trc_valid}, {63'd0, vecs[i].valid_e});
      checkOutput($sformatf("vec%0d pc", i), {32'd0, trc_pc}, {32'd0, vecs[i].pc_e});
      checkOutput($sformatf("vec%0d ena", i), {63'd0, trc_ena}, {63'd0, vecs[i].ena_e});
      checkOutput($sformatf("vec%0d reg", i), {59'd0, trc_reg}, {59'd0, vecs[i].reg_e});
      checkOutput($sformatf("vec%0d value", i), {32'd0, trc_value}, {32'd0, vecs[i].val_e});
      checkOutput($sformatf("vec%0d level", i), {61'd0, level}, {61'd0, vecs[i].level_e});
      checkOutput($sformatf("vec%0d drop", i), {48'd0, drop_cnt}, 64'd0);
    end

    // Overfill: six captures into four slots, two are dropped.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b1, 5'd1, 32'(i), 1'b0, 1'b0);
      waitCycle();
    end
    checkOutput("overfill level", {61'd0, level}, 64'd4);
    checkOutput("overfill drop", {48'd0, drop_cnt}, 64'd2);
    checkOutput("overfill head", {32'd0, trc_pc}, 64'h100);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      checkOutput($sformatf("overfill drain%0d", i), {32'd0, trc_pc}, 64'h100 + 64'(4 * i));
      waitCycle();
    end
    checkOutput("overfill empty", {63'd0, trc_valid}, 64'd0);

    applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    waitCycle();
    checkOutput("flush clears drop", {48'd0, drop_cnt}, 64'd0);

    // Full buffer, capture and pop together across the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(4 * i), 1'b1, 5'd2, 32'd0, 1'b0, 1'b0);
      waitCycle();
    end
    checkOutput("wrap fill level", {61'd0, level}, 64'd4);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'h210 + 32'(4 * k), 1'b1, 5'd2, 32'd0, 1'b1, 1'b0);
      checkOutput($sformatf("wrap head%0d", k), {32'd0, trc_pc}, 64'h200 + 64'(4 * k));
      waitCycle();
      checkOutput($sformatf("wrap level%0d", k), {61'd0, level}, 64'd4);
      checkOutput($sformatf("wrap drop%0d", k), {48'd0, drop_cnt}, 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      checkOutput($sformatf("wrap drain%0d", i), {32'd0, trc_pc}, 64'h228 + 64'(4 * i));
      waitCycle();
    end

    // Level 3 with seven drops, then flush with a same-cycle capture.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 32'h400 + 32'(4 * i), 1'b1, 5'd3, 32'd0, 1'b0, 1'b0);
      waitCycle();
    end
    checkOutput("pre-flush drop", {48'd0, drop_cnt}, 64'd7);
    applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    waitCycle();
    checkOutput("pre-flush level", {61'd0, level}, 64'd3);
    applyStimulus(1'b1, 32'h500, 1'b1, 5'd3, 32'd9, 1'b0, 1'b1);
    waitCycle();
    checkOutput("flush level", {61'd0, level}, 64'd0);
    checkOutput("flush drop", {48'd0, drop_cnt}, 64'd0);
    checkOutput("flush valid", {63'd0, trc_valid}, 64'd0);
    applyStimulus(1'b1, 32'h504, 1'b1, 5'd3, 32'd9, 1'b0, 1'b0);
    waitCycle();
    checkOutput("post-flush head", {32'd0, trc_pc}, 64'h504);
    checkOutput("post-flush level", {61'd0, level}, 64'd1);

    // Asynchronous reset in the middle of a drain.
    applyStimulus(1'b1, 32'h508, 1'b1, 5'd3, 32'd9, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b1, 32'h50C, 1'b1, 5'd3, 32'd9, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    waitCycle();
    checkOutput("mid-drain level", {61'd0, level}, 64'd2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset valid", {63'd0, trc_valid}, 64'd0);
    checkOutput("async reset level", {61'd0, level}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h300, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    waitCycle();
    checkOutput("after reset head", {32'd0, trc_pc}, 64'h300);
    checkOutput("after reset level", {61'd0, level}, 64'd1);

    // Filtered instance keeps only real register writes.
    applyStimulus(1'b1, 32'h600, 1'b0, 5'd4, 32'h11, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b1, 32'h604, 1'b1, 5'd0, 32'h22, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b1, 32'h608, 1'b1, 5'd3, 32'hCAFE, 1'b0, 1'b0);
    waitCycle();
    checkOutput("filter level", {61'd0, f_level}, 64'd1);
    checkOutput("filter pc", {32'd0, f_pc}, 64'h608);
    checkOutput("filter reg", {59'd0, f_reg}, 64'd3);
    checkOutput("filter value", {32'd0, f_value}, 64'hCAFE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
